// File: rtl/tri_fetch_engine.sv
// Per-frame triangle fetch engine: walks instance descriptors, reads index triples and vertices,
// and hands assembled triangles to the transform stage through a staging + output buffer pair.
package tri_fetch_pkg;
   typedef struct packed {
      logic [15:0] z;
      logic [15:0] y;
      logic [15:0] x;
   } vertex_t;

   typedef struct packed {
      vertex_t v2;
      vertex_t v1;
      vertex_t v0;
   } triangle_t;
endpackage

module tri_fetch_engine
   import tri_fetch_pkg::*;
#(
   parameter int MAX_VERT     = 8192,
   parameter int MAX_TRI      = 8192,
   parameter int MAX_INST     = 16,
   parameter int MAX_TRI_CNT  = 256,
   parameter int MAX_VERT_CNT = 256,
   parameter int RD_LAT       = 1,
   localparam int VA_W   = $clog2(MAX_VERT),
   localparam int TA_W   = $clog2(MAX_TRI),
   localparam int IID_W  = $clog2(MAX_INST),
   localparam int TIDX_W = $clog2(MAX_TRI_CNT) + 1,
   localparam int VIDX_W = $clog2(MAX_VERT_CNT),
   localparam int TRI_W  = 3 * VIDX_W
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [IID_W:0]    inst_count,
   output logic [IID_W-1:0]  desc_inst_id,
   input  logic [VA_W-1:0]   desc_vert_base,
   input  logic [TA_W-1:0]   desc_tri_base,
   input  logic [TIDX_W-1:0] desc_tri_count,
   output logic              tri_rd_en,
   output logic [TA_W-1:0]   tri_addr,
   input  logic [TRI_W-1:0]  idx_tri,
   output logic              vert_rd_en,
   output logic [VA_W-1:0]   vert_addr,
   input  vertex_t           vert_in,
   output logic              tri_valid,
   input  logic              tri_ready,
   output triangle_t         tri_out,
   output logic [IID_W-1:0]  tri_inst_id,
   output logic              tri_last,
   output logic              busy,
   output logic              frame_done
);

   typedef enum logic [2:0] {
      S_IDLE, S_DESC, S_IDX, S_IWAIT, S_VTX, S_STAGE, S_DRAIN
   } state_t;

   state_t state, state_nx;

   logic              desc_ph;
   logic [IID_W:0]    inst_cnt_r;
   logic [IID_W-1:0]  inst_ctr;
   logic [VA_W-1:0]   vert_base_r;
   logic [TA_W-1:0]   tri_base_r;
   logic [TIDX_W-1:0] tri_cnt_r;
   logic [TIDX_W-1:0] tri_ctr;
   logic [TRI_W-1:0]  idx_r;
   logic [1:0]        vcnt;
   logic [VIDX_W-1:0] vidx;
   vertex_t           v0_r, v1_r;

   // Delayed copies of the read strobes mark the cycle each read returns.
   logic [RD_LAT-1:0]      ivld_pipe;
   logic [RD_LAT-1:0]      vvld_pipe;
   logic [RD_LAT-1:0][1:0] vsel_pipe;

   logic              stg_full, stg_known, stg_last;
   triangle_t         stg_tri;
   logic [IID_W-1:0]  stg_iid;

   logic idx_cap, v2_cap, tri_final, inst_final, out_load;

   assign idx_cap    = ivld_pipe[RD_LAT-1];
   assign v2_cap     = vvld_pipe[RD_LAT-1] && (vsel_pipe[RD_LAT-1] == 2'd2);
   assign tri_final  = (TIDX_W'(tri_ctr + 1'b1) == tri_cnt_r);
   assign inst_final = ({1'b0, inst_ctr} == (IID_W+1)'(inst_cnt_r - 1'b1));
   // A staged triangle whose last-ness is still unknown waits until a later descriptor decides it.
   assign out_load   = stg_full && stg_known && (!tri_valid || tri_ready);

   assign desc_inst_id = inst_ctr;
   assign busy         = (state != S_IDLE);
   assign tri_addr     = tri_base_r + TA_W'(tri_ctr);
   assign vert_addr    = vert_base_r + VA_W'(vidx);

   always_comb begin
      vidx = idx_r[VIDX_W-1:0];
      if (vcnt == 2'd1)      vidx = idx_r[2*VIDX_W-1:VIDX_W];
      else if (vcnt == 2'd2) vidx = idx_r[3*VIDX_W-1:2*VIDX_W];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      tri_rd_en  = 1'b0;
      vert_rd_en = 1'b0;
      case (state)
         S_IDLE:  if (start) state_nx = (inst_count == '0) ? S_DRAIN : S_DESC;
         S_DESC:  if (desc_ph) begin
                     if (desc_tri_count != '0) state_nx = S_IDX;
                     else if (inst_final)      state_nx = S_DRAIN;
                  end
         S_IDX:   if (!stg_full) begin
                     tri_rd_en = 1'b1;
                     state_nx  = S_IWAIT;
                  end
         S_IWAIT: if (idx_cap) state_nx = S_VTX;
         S_VTX:   begin
                     vert_rd_en = 1'b1;
                     if (vcnt == 2'd2) state_nx = S_STAGE;
                  end
         S_STAGE: if (v2_cap) begin
                     if (!tri_final)      state_nx = S_IDX;
                     else if (inst_final) state_nx = S_DRAIN;
                     else                 state_nx = S_DESC;
                  end
         S_DRAIN: if (!stg_full && (!tri_valid || tri_ready)) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         desc_ph     <= 1'b0;
         inst_cnt_r  <= '0;
         inst_ctr    <= '0;
         vert_base_r <= '0;
         tri_base_r  <= '0;
         tri_cnt_r   <= '0;
         tri_ctr     <= '0;
         idx_r       <= '0;
         vcnt        <= '0;
         v0_r        <= '0;
         v1_r        <= '0;
         ivld_pipe   <= '0;
         vvld_pipe   <= '0;
         vsel_pipe   <= '0;
         stg_full    <= 1'b0;
         stg_known   <= 1'b0;
         stg_last    <= 1'b0;
         stg_tri     <= '0;
         stg_iid     <= '0;
         tri_valid   <= 1'b0;
         tri_out     <= '0;
         tri_inst_id <= '0;
         tri_last    <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         frame_done   <= (state == S_DRAIN) && (state_nx == S_IDLE);
         ivld_pipe[0] <= tri_rd_en;
         vvld_pipe[0] <= vert_rd_en;
         vsel_pipe[0] <= vcnt;
         for (int k = 1; k < RD_LAT; k++) begin
            ivld_pipe[k] <= ivld_pipe[k-1];
            vvld_pipe[k] <= vvld_pipe[k-1];
            vsel_pipe[k] <= vsel_pipe[k-1];
         end

         case (state)
            S_IDLE: if (start) begin
               inst_cnt_r <= inst_count;
               inst_ctr   <= '0;
               desc_ph    <= 1'b0;
            end
            S_DESC: begin
               desc_ph <= !desc_ph;
               if (desc_ph) begin
                  vert_base_r <= desc_vert_base;
                  tri_base_r  <= desc_tri_base;
                  tri_cnt_r   <= desc_tri_count;
                  tri_ctr     <= '0;
                  if (desc_tri_count == '0 && !inst_final) inst_ctr <= inst_ctr + 1'b1;
                  if (stg_full && !stg_known) begin
                     if (desc_tri_count != '0) begin
                        stg_known <= 1'b1;
                        stg_last  <= 1'b0;
                     end else if (inst_final) begin
                        stg_known <= 1'b1;
                        stg_last  <= 1'b1;
                     end
                  end
               end
            end
            S_IWAIT: if (idx_cap) idx_r <= idx_tri;
            S_VTX:   vcnt <= (vcnt == 2'd2) ? 2'd0 : vcnt + 2'd1;
            S_STAGE: if (v2_cap) begin
               if (!tri_final) begin
                  tri_ctr <= tri_ctr + 1'b1;
               end else if (!inst_final) begin
                  inst_ctr <= inst_ctr + 1'b1;
                  desc_ph  <= 1'b0;
               end
            end
            default: ;
         endcase

         if (vvld_pipe[RD_LAT-1] && vsel_pipe[RD_LAT-1] == 2'd0) v0_r <= vert_in;
         if (vvld_pipe[RD_LAT-1] && vsel_pipe[RD_LAT-1] == 2'd1) v1_r <= vert_in;

         // Staging is always empty while in STAGE, since IDX waits for it to drain.
         if (state == S_STAGE && v2_cap) begin
            stg_full  <= 1'b1;
            stg_tri   <= '{v2: vert_in, v1: v1_r, v0: v0_r};
            stg_iid   <= inst_ctr;
            stg_known <= !tri_final || inst_final;
            stg_last  <= tri_final && inst_final;
         end else if (out_load) begin
            stg_full <= 1'b0;
         end

         if (out_load) begin
            tri_valid   <= 1'b1;
            tri_out     <= stg_tri;
            tri_inst_id <= stg_iid;
            tri_last    <= stg_last;
         end else if (tri_ready) begin
            tri_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tri_fetch_engine.sv
// Scoreboard bench for tri_fetch_engine: RD_LAT=1 instance for frame/handshake behaviour,
// RD_LAT=3 instance for address wrap and read-latency capture.
module tb_tri_fetch_engine;
   import tri_fetch_pkg::*;

   localparam int IID_W = 4, VA_W = 13, TA_W = 13, TIDX_W = 9, TRI_W = 24;
   localparam logic [47:0] JUNK_V = 48'hdeaddeaddead;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic              start, tri_ready;
   logic [IID_W:0]    inst_count;
   logic [IID_W-1:0]  desc_inst_id, tri_inst_id;
   logic [VA_W-1:0]   desc_vert_base, vert_addr;
   logic [TA_W-1:0]   desc_tri_base, tri_addr;
   logic [TIDX_W-1:0] desc_tri_count;
   logic              tri_rd_en, vert_rd_en, tri_valid, tri_last, busy, frame_done;
   logic [TRI_W-1:0]  idx_tri;
   vertex_t           vert_in;
   triangle_t         tri_out;

   logic              start_3;
   logic [IID_W-1:0]  desc_inst_id_3, tri_inst_id_3;
   logic [VA_W-1:0]   vert_addr_3;
   logic [TA_W-1:0]   tri_addr_3;
   logic              tri_rd_en_3, vert_rd_en_3, tri_valid_3, tri_last_3, busy_3, frame_done_3;
   logic [TRI_W-1:0]  idx_tri_3;
   vertex_t           vert_in_3;
   triangle_t         tri_out_3;

   tri_fetch_engine #(.RD_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .inst_count(inst_count),
      .desc_inst_id(desc_inst_id), .desc_vert_base(desc_vert_base),
      .desc_tri_base(desc_tri_base), .desc_tri_count(desc_tri_count),
      .tri_rd_en(tri_rd_en), .tri_addr(tri_addr), .idx_tri(idx_tri),
      .vert_rd_en(vert_rd_en), .vert_addr(vert_addr), .vert_in(vert_in),
      .tri_valid(tri_valid), .tri_ready(tri_ready), .tri_out(tri_out),
      .tri_inst_id(tri_inst_id), .tri_last(tri_last), .busy(busy), .frame_done(frame_done)
   );

   tri_fetch_engine #(.RD_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start_3), .inst_count(5'd1),
      .desc_inst_id(desc_inst_id_3), .desc_vert_base(13'd8190),
      .desc_tri_base(13'd0), .desc_tri_count(9'd1),
      .tri_rd_en(tri_rd_en_3), .tri_addr(tri_addr_3), .idx_tri(idx_tri_3),
      .vert_rd_en(vert_rd_en_3), .vert_addr(vert_addr_3), .vert_in(vert_in_3),
      .tri_valid(tri_valid_3), .tri_ready(1'b1), .tri_out(tri_out_3),
      .tri_inst_id(tri_inst_id_3), .tri_last(tri_last_3), .busy(busy_3), .frame_done(frame_done_3)
   );

   function automatic vertex_t vdata(input logic [VA_W-1:0] a);
      vertex_t v;
      v.x = {3'd0, a};
      v.y = 16'h5a5a ^ {a, 3'd0};
      v.z = ~{3'd0, a};
      return v;
   endfunction

   function automatic logic [TRI_W-1:0] itri(input logic [TA_W-1:0] a);
      logic [7:0] b;
      b = a[7:0];
      return {b + 8'd7, b + 8'd3, b};
   endfunction

   // Descriptor table and memories; non-returning cycles carry junk so mistimed captures show up.
   logic [VA_W-1:0]   d_vb [16];
   logic [TA_W-1:0]   d_tb [16];
   logic [TIDX_W-1:0] d_tc [16];

   always @(posedge clk) begin
      desc_vert_base <= d_vb[desc_inst_id];
      desc_tri_base  <= d_tb[desc_inst_id];
      desc_tri_count <= d_tc[desc_inst_id];
      idx_tri        <= tri_rd_en ? itri(tri_addr) : 24'hbadbad;
      vert_in        <= vert_rd_en ? vdata(vert_addr) : vertex_t'(JUNK_V);
   end

   logic [1:0]      i3v = '0, v3v = '0;
   logic [VA_W-1:0] v3a0, v3a1;
   always @(posedge clk) begin
      i3v       <= {i3v[0], tri_rd_en_3};
      v3v       <= {v3v[0], vert_rd_en_3};
      v3a0      <= vert_addr_3;
      v3a1      <= v3a0;
      idx_tri_3 <= i3v[1] ? {8'd3, 8'd2, 8'd1} : 24'hbadbad;
      vert_in_3 <= v3v[1] ? vdata(v3a1) : vertex_t'(JUNK_V);
   end

   typedef struct {
      triangle_t        t;
      logic [IID_W-1:0] id;
      logic             last;
   } exp_t;

   exp_t             sbq[$];
   logic [IID_W-1:0] acc_id[$];
   logic             acc_last[$];
   int vec_cnt = 0, err_cnt = 0;
   int done_cnt = 0, rd_cnt = 0, vr_cnt = 0, tv_cnt = 0;

   task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   logic         hold_chk = 1'b0;
   logic [191:0] hold_val;
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_chk = 1'b0;
      end else begin
         if (frame_done) done_cnt++;
         if (tri_rd_en)  rd_cnt++;
         if (vert_rd_en) vr_cnt++;
         if (tri_valid)  tv_cnt++;
         if (hold_chk) begin
            chk("held tri_valid", 192'(tri_valid), 192'(1));
            chk("held payload", 192'({tri_out, tri_inst_id, tri_last}), hold_val);
         end
         hold_chk = tri_valid && !tri_ready;
         hold_val = 192'({tri_out, tri_inst_id, tri_last});
         if (tri_valid && tri_ready) begin
            acc_id.push_back(tri_inst_id);
            acc_last.push_back(tri_last);
            if (sbq.size() == 0) begin
               chk("unexpected triangle", 192'(acc_id.size()), 192'(0));
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("tri_out", 192'(tri_out), 192'(e.t));
               chk("tri_inst_id", 192'(tri_inst_id), 192'(e.id));
               chk("tri_last", 192'(tri_last), 192'(e.last));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input int n);
      exp_t e;
      int   pushed;
      pushed = 0;
      for (int i = 0; i < n; i++) begin
         for (int t = 0; t < int'(d_tc[i]); t++) begin
            logic [TA_W-1:0]  ta;
            logic [TRI_W-1:0] tr;
            ta = TA_W'(int'(d_tb[i]) + t);
            tr = itri(ta);
            e.t.v0 = vdata(VA_W'(int'(d_vb[i]) + int'(tr[7:0])));
            e.t.v1 = vdata(VA_W'(int'(d_vb[i]) + int'(tr[15:8])));
            e.t.v2 = vdata(VA_W'(int'(d_vb[i]) + int'(tr[23:16])));
            e.id   = IID_W'(i);
            e.last = 1'b0;
            sbq.push_back(e);
            pushed++;
         end
      end
      if (pushed > 0) begin
         e = sbq.pop_back();
         e.last = 1'b1;
         sbq.push_back(e);
      end
   endtask

   task automatic start_frame(input int n);
      inst_count = 5'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int budget);
      logic got;
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         tick();
         if (frame_done) got = 1'b1;
      end
      chk(nm, 192'(got), 192'(1));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, b0, r0, v0, t0, n3;
      logic got;
      logic [VA_W-1:0] va3[3];
      logic [191:0] tri3;
      logic [IID_W:0] tag3;

      rst_n = 1'b0; start = 1'b0; start_3 = 1'b0; tri_ready = 1'b1; inst_count = '0;
      for (int i = 0; i < 16; i++) begin
         d_vb[i] = '0; d_tb[i] = '0; d_tc[i] = '0;
      end
      tick(); tick(); tick();
      chk("reset outputs", 192'({tri_valid, busy, frame_done, tri_rd_en, vert_rd_en,
          desc_inst_id, tri_addr, vert_addr, tri_out, tri_last}), 192'(0));
      rst_n = 1'b1;
      tick();

      // Two instances, counts {1,2}; second instance tri base wraps 8191 -> 0.
      d_vb[0] = 13'd100;  d_tb[0] = 13'd10;   d_tc[0] = 9'd1;
      d_vb[1] = 13'd8000; d_tb[1] = 13'd8191; d_tc[1] = 9'd2;
      push_frame(2);
      d0 = done_cnt; b0 = acc_id.size();
      start_frame(2);
      chk("busy after start", 192'(busy), 192'(1));
      wait_done("frame A done", 400);
      chk("busy at done", 192'(busy), 192'(0));
      tick(); tick(); tick();
      chk("frame A done pulses", 192'(done_cnt - d0), 192'(1));
      chk("frame A triangles", 192'(acc_id.size() - b0), 192'(3));
      if (acc_id.size() - b0 == 3) begin
         chk("frame A ids", 192'({acc_id[b0], acc_id[b0+1], acc_id[b0+2]}), 192'({4'd0, 4'd1, 4'd1}));
         chk("frame A last", 192'({acc_last[b0], acc_last[b0+1], acc_last[b0+2]}), 192'(3'b001));
      end

      // Backpressure: 20-cycle stall after the first triangle is accepted.
      d_vb[0] = 13'd500; d_tb[0] = 13'd200; d_tc[0] = 9'd5;
      push_frame(1);
      b0 = acc_id.size();
      start_frame(1);
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         tick();
         if (acc_id.size() > b0) got = 1'b1;
      end
      chk("frame B first accept", 192'(got), 192'(1));
      tri_ready = 1'b0;
      r0 = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i == 11) r0 = rd_cnt;
      end
      chk("stall no fetch", 192'(rd_cnt - r0), 192'(0));
      chk("stall valid held", 192'(tri_valid), 192'(1));
      tri_ready = 1'b1;
      wait_done("frame B done", 400);
      tick();
      chk("frame B triangles", 192'(acc_id.size() - b0), 192'(5));
      chk("frame B scoreboard empty", 192'(sbq.size()), 192'(0));

      // Counts {0,3,0}, plus a start while busy that must be ignored.
      d_tc[0] = 9'd0;
      d_vb[1] = 13'd40; d_tb[1] = 13'd300; d_tc[1] = 9'd3;
      d_tc[2] = 9'd0;
      push_frame(3);
      d0 = done_cnt; b0 = acc_id.size();
      start_frame(3);
      tick(); tick();
      inst_count = 5'd2; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("frame C done", 400);
      for (int i = 0; i < 30; i++) tick();
      chk("frame C done pulses", 192'(done_cnt - d0), 192'(1));
      chk("frame C triangles", 192'(acc_id.size() - b0), 192'(3));
      if (acc_id.size() - b0 == 3) begin
         chk("frame C ids", 192'({acc_id[b0], acc_id[b0+1], acc_id[b0+2]}), 192'({4'd1, 4'd1, 4'd1}));
         chk("frame C last", 192'({acc_last[b0], acc_last[b0+1], acc_last[b0+2]}), 192'(3'b001));
      end
      chk("frame C idle", 192'(busy), 192'(0));

      // Empty frame: frame_done two cycles after start, nothing fetched.
      r0 = rd_cnt; v0 = vr_cnt; t0 = tv_cnt;
      start_frame(0);
      chk("empty busy", 192'({busy, frame_done}), 192'(2'b10));
      tick();
      chk("empty done", 192'({busy, frame_done}), 192'(2'b01));
      tick();
      chk("empty done pulse", 192'(frame_done), 192'(0));
      chk("empty no activity", 192'({rd_cnt - r0, vr_cnt - v0, tv_cnt - t0}), 192'(0));

      // Reset in VTX, then a clean frame from instance 0.
      d_tc[0] = 9'd0;
      d_vb[1] = 13'd7; d_tb[1] = 13'd9; d_tc[1] = 9'd2;
      start_frame(2);
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         if (vert_rd_en) got = 1'b1;
         else tick();
      end
      chk("reached VTX", 192'({got, desc_inst_id}), 192'({1'b1, 4'd1}));
      #2 rst_n = 1'b0;
      #1;
      chk("async reset outputs", 192'({tri_valid, busy, frame_done, tri_rd_en, vert_rd_en,
          desc_inst_id, tri_last}), 192'(0));
      sbq.delete();
      tick(); tick();
      rst_n = 1'b1;
      tick();
      d_vb[0] = 13'd60; d_tb[0] = 13'd77; d_tc[0] = 9'd1;
      push_frame(1);
      b0 = acc_id.size();
      start_frame(1);
      wait_done("post-reset done", 200);
      tick();
      chk("post-reset triangles", 192'(acc_id.size() - b0), 192'(1));
      if (acc_id.size() - b0 == 1)
         chk("post-reset id/last", 192'({acc_id[b0], acc_last[b0]}), 192'({4'd0, 1'b1}));

      // RD_LAT=3 with vertex base 8190 and indices {1,2,3}.
      n3 = 0; tri3 = '0; tag3 = '0; got = 1'b0;
      start_3 = 1'b1;
      tick();
      start_3 = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         if (vert_rd_en_3 && n3 < 3) begin
            va3[n3] = vert_addr_3;
            n3++;
         end
         if (tri_valid_3) begin
            tri3 = 192'(tri_out_3);
            tag3 = {tri_inst_id_3, tri_last_3};
         end
         if (frame_done_3) got = 1'b1;
         tick();
      end
      chk("lat3 done", 192'(got), 192'(1));
      chk("lat3 strobes", 192'(n3), 192'(3));
      chk("lat3 vert_addr", 192'({va3[0], va3[1], va3[2]}), 192'({13'd8191, 13'd0, 13'd1}));
      chk("lat3 tri_out", tri3, 192'({vdata(13'd1), vdata(13'd0), vdata(13'd8191)}));
      chk("lat3 id/last", 192'(tag3), 192'({4'd0, 1'b1}));

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
